// File: rtl/framebuffer_readback_tx_pkg.sv
// framebuffer_readback_tx_pkg
// Row-load protocol constants and the readback FSM state encoding. The
// receive parser in control_module uses the same constants.
//   CMD_ROW_LOAD  : command byte that opens a row frame ("L")
//   FRAME_TERM    : byte that closes a row frame (line feed)
//   ASCII_ZERO    : base for the two decimal row digits
//   BYTES_PER_ROW : data bytes carried in one row frame
//   fb_state_t    : readback FSM states
//   row_digit()   : ASCII tens or units digit of a 5-bit row number
package framebuffer_readback_tx_pkg;

  localparam logic [7:0] CMD_ROW_LOAD  = 8'h4C;
  localparam logic [7:0] FRAME_TERM    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam int         BYTES_PER_ROW = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_TRAIL = 3'd5,
    ST_FIN   = 3'd6
  } fb_state_t;

  // Rows only span 0..31, so the tens digit is 0..3 and the units 0..9.
  function automatic logic [7:0] row_digit(input logic [4:0] r, input logic tens);
    if (tens) begin
      return ASCII_ZERO + {3'b000, r / 5'd10};
    end
    return ASCII_ZERO + {3'b000, r % 5'd10};
  endfunction

endpackage

// File: rtl/framebuffer_readback_tx_uart_tx_byte.sv
// uart_tx_byte
// Serialises one byte as 8N1 (start 0, data LSB first, stop 1). Each bit
// cell lasts exactly TICKS_PER_BIT clocks. The line idles high.
// Ports:
//   clk_in    : clock
//   reset     : asynchronous active-low reset
//   load      : byte offer (valid)
//   data      : byte to send, sampled with an accepted load
//   tx_out    : serial line
//   active    : a byte is on the line (not ready)
//   byte_done : one-cycle pulse in the last clock of the stop bit
//
// Handshake: load is a valid strobe and !active is ready; a byte transfers
// in a cycle with load && !active, and its start bit begins on the next
// cycle. A load while active is dropped. byte_done marks the final stop-bit
// clock, so the owner may offer the next byte from the following cycle.
module uart_tx_byte #(
  parameter int TICKS_PER_BIT = 20,
  parameter int TICKS_WIDTH   = 5
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx_out,
  output logic       active,
  output logic       byte_done
);

  localparam logic [TICKS_WIDTH-1:0] TICK_LAST = TICKS_WIDTH'(TICKS_PER_BIT - 1);

  logic [TICKS_WIDTH-1:0] tick_cnt;
  logic [3:0]             bit_cnt;
  logic [9:0]             shreg;

  logic cell_end;
  assign cell_end  = active && (tick_cnt == TICK_LAST);
  assign byte_done = cell_end && (bit_cnt == 4'd9);
  assign tx_out    = ~active | shreg[0];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (!active) begin
      if (load) begin
        active   <= 1'b1;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= {1'b1, data, 1'b0};
      end
    end else if (cell_end) begin
      tick_cnt <= '0;
      shreg    <= {1'b1, shreg[9:1]};
      if (bit_cnt == 4'd9) begin
        active <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else begin
      tick_cnt <= tick_cnt + TICKS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/framebuffer_readback_tx.sv
// framebuffer_readback_tx
// Reads one framebuffer row through the multimem A-side read port and sends
// it over UART as a row-load frame: "L", two decimal row digits, the row's
// data bytes, then a line feed.
// Ports:
//   clk_in         : clock (clk_root)
//   reset          : asynchronous active-low reset
//   start          : one-cycle dump request, ignored while busy
//   row            : row to dump, sampled on the accepted start
//   abort          : cancel; the byte on the line still completes
//   ram_data_in    : read data, valid the cycle after ram_clk_enable
//   ram_address    : {row, byte index}
//   ram_clk_enable : read strobe, one cycle per data byte
//   tx_out         : UART line, idle high
//   busy           : frame in progress
//   done           : one-cycle pulse after the trailer's stop bit
//   bytes_sent     : bytes completed in the current frame
//   state_dbg      : current FSM state (fb_state_t encoding)
//
// Every byte is preceded by exactly three idle-high clocks: FETCH, WAIT and
// the load cycle for data bytes, and a matching three-cycle gap count for
// header and trailer bytes, so the line timing is uniform across the frame.
module framebuffer_readback_tx #(
  parameter int TICKS_PER_BIT = 20,
  parameter int TICKS_WIDTH   = 5,
  parameter int BYTES_PER_ROW = 128,
  parameter int ADDR_WIDTH    = 12
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            row,
  input  logic                  abort,
  input  logic [7:0]            ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_clk_enable,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            bytes_sent,
  output logic [2:0]            state_dbg
);

  import framebuffer_readback_tx_pkg::*;

  localparam int IDX_W = $clog2(BYTES_PER_ROW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_ROW - 1);

  fb_state_t        state, state_n;
  logic [4:0]       row_q;
  logic [IDX_W-1:0] idx;
  logic [1:0]       hdr_cnt;
  logic [1:0]       gap_cnt;
  logic             launched;
  logic             abort_q;
  logic [7:0]       tx_hold;

  logic       uart_load;
  logic [7:0] uart_data;
  logic       uart_active;
  logic       byte_done;
  logic       gap_run;
  logic       in_frame;
  logic       stopping;
  logic       start_ok;
  logic [7:0] hdr_byte;

  uart_tx_byte #(
    .TICKS_PER_BIT (TICKS_PER_BIT),
    .TICKS_WIDTH   (TICKS_WIDTH)
  ) u_uart (
    .clk_in    (clk_in),
    .reset     (reset),
    .load      (uart_load),
    .data      (uart_data),
    .tx_out    (tx_out),
    .active    (uart_active),
    .byte_done (byte_done)
  );

  assign in_frame = (state != ST_IDLE) && (state != ST_FIN);
  // Once abort is seen, no new byte is offered; the frame ends when the
  // line is free.
  assign stopping = in_frame && (abort || abort_q);
  // abort beats a simultaneous start.
  assign start_ok = (state == ST_IDLE) && start && !abort;

  assign busy           = in_frame;
  assign done           = (state == ST_FIN);
  assign ram_clk_enable = (state == ST_FETCH) && !stopping;
  assign ram_address    = ADDR_WIDTH'({row_q, idx});
  assign state_dbg      = state;

  always_comb begin
    case (hdr_cnt)
      2'd0:    hdr_byte = CMD_ROW_LOAD;
      2'd1:    hdr_byte = row_digit(row_q, 1'b1);
      default: hdr_byte = row_digit(row_q, 1'b0);
    endcase
  end

  always_comb begin
    state_n   = state;
    uart_load = 1'b0;
    uart_data = tx_hold;
    gap_run   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_n = ST_HDR;
      end
      ST_HDR: begin
        uart_data = hdr_byte;
        if (!launched) begin
          if (gap_cnt == 2'd2) uart_load = 1'b1;
          else                 gap_run   = 1'b1;
        end else if (byte_done && (hdr_cnt == 2'd2)) begin
          state_n = ST_FETCH;
        end
      end
      ST_FETCH: state_n = ST_WAIT;
      ST_WAIT:  state_n = ST_SEND;
      ST_SEND: begin
        if (!launched) begin
          uart_load = 1'b1;
        end else if (byte_done) begin
          state_n = (idx == IDX_LAST) ? ST_TRAIL : ST_FETCH;
        end
      end
      ST_TRAIL: begin
        uart_data = FRAME_TERM;
        if (!launched) begin
          if (gap_cnt == 2'd2) uart_load = 1'b1;
          else                 gap_run   = 1'b1;
        end else if (byte_done) begin
          state_n = ST_FIN;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (stopping) begin
      uart_load = 1'b0;
      gap_run   = 1'b0;
      if (!uart_active || byte_done) state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      row_q      <= '0;
      idx        <= '0;
      hdr_cnt    <= '0;
      gap_cnt    <= '0;
      launched   <= 1'b0;
      abort_q    <= 1'b0;
      tx_hold    <= '0;
      bytes_sent <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        row_q      <= row;
        idx        <= '0;
        hdr_cnt    <= '0;
        gap_cnt    <= '0;
        launched   <= 1'b0;
        bytes_sent <= '0;
      end
      if (uart_load) begin
        launched <= 1'b1;
        gap_cnt  <= '0;
      end else if (gap_run) begin
        gap_cnt <= gap_cnt + 2'd1;
      end
      if (byte_done) begin
        launched   <= 1'b0;
        bytes_sent <= bytes_sent + 8'd1;
        if (state == ST_HDR)  hdr_cnt <= hdr_cnt + 2'd1;
        // The last index wraps to 0 on the way into TRAIL.
        if (state == ST_SEND) idx <= idx + IDX_W'(1);
      end
      if (state == ST_WAIT) tx_hold <= ram_data_in;
      if (state_n == ST_IDLE)       abort_q <= 1'b0;
      else if (abort && in_frame)   abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_framebuffer_readback_tx.sv
// tb_framebuffer_readback_tx
// Drives framebuffer row dumps and decodes the UART line back into bytes,
// comparing against frames built from the row-load format and a memory image.
module tb_framebuffer_readback_tx;
  import framebuffer_readback_tx_pkg::*;

  localparam int TPB         = 4;
  localparam int FRAME_BYTES = 132;
  localparam int BUSY_CYCLES = 3 + FRAME_BYTES * 10 * TPB + (FRAME_BYTES - 1) * 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic [4:0]  row    = 5'd0;
  logic [7:0]  ram_data_in;
  logic [11:0] ram_address;
  logic        ram_clk_enable;
  logic        tx_out;
  logic        busy;
  logic        done;
  logic [7:0]  bytes_sent;
  logic [2:0]  state_dbg;

  always #5 clk_in = ~clk_in;

  framebuffer_readback_tx #(
    .TICKS_PER_BIT (TPB),
    .TICKS_WIDTH   (3),
    .BYTES_PER_ROW (128),
    .ADDR_WIDTH    (12)
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .start          (start),
    .row            (row),
    .abort          (abort),
    .ram_data_in    (ram_data_in),
    .ram_address    (ram_address),
    .ram_clk_enable (ram_clk_enable),
    .tx_out         (tx_out),
    .busy           (busy),
    .done           (done),
    .bytes_sent     (bytes_sent),
    .state_dbg      (state_dbg)
  );

  // ---------------- framebuffer model ----------------
  logic [7:0] mem [0:4095];
  logic [7:0] ram_q = 8'h00;
  assign ram_data_in = ram_q;
  always @(posedge clk_in) if (ram_clk_enable === 1'b1) ram_q <= mem[ram_address];

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         done_cnt, busy_cyc, out_of_range, cell_err, frame_err;
  int         strobe_cnt [0:4095];
  logic [4:0] exp_row = 5'd0;

  // ---------------- line monitor / UART receiver ----------------
  bit         rx_active = 1'b0;
  int         rx_cyc    = 0;
  int         high_run  = 0;
  logic [7:0] rx_sh;
  logic       cell_val;

  always @(negedge clk_in) begin
    if (!reset) begin
      rx_active = 1'b0;
      rx_cyc    = 0;
      high_run  = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cyc++;
      if (ram_clk_enable === 1'b1) begin
        strobe_cnt[ram_address]++;
        if (ram_address[11:7] !== exp_row) out_of_range++;
      end
      if (!rx_active) begin
        if (tx_out === 1'b1) begin
          high_run++;
        end else begin
          gap_q.push_back(high_run);
          rx_active = 1'b1;
          rx_cyc    = 1;
          cell_val  = 1'b0;
        end
      end else begin
        if (rx_cyc % TPB == 0) begin
          cell_val = tx_out;
          if (rx_cyc / TPB >= 1 && rx_cyc / TPB <= 8) rx_sh[rx_cyc / TPB - 1] = tx_out;
          if (rx_cyc / TPB == 9 && tx_out !== 1'b1) frame_err++;
        end else if (tx_out !== cell_val) begin
          cell_err++;
        end
        rx_cyc++;
        if (rx_cyc == 10 * TPB) begin
          rx_q.push_back(rx_sh);
          rx_active = 1'b0;
          high_run  = 0;
        end
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    gap_q.delete();
    done_cnt = 0; busy_cyc = 0; out_of_range = 0; cell_err = 0; frame_err = 0;
    for (int i = 0; i < 4096; i++) strobe_cnt[i] = 0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Expected frame from the row-load format.
  task automatic build_exp(input logic [4:0] r);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'(8'h30 + int'(r) / 10));
    exp_q.push_back(8'(8'h30 + int'(r) % 10));
    for (int i = 0; i < 128; i++) exp_q.push_back(mem[int'(r) * 128 + i]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start(input logic [4:0] r);
    @(negedge clk_in);
    row   = r;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk_in);
      #1;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic wait_bytes(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk_in);
      #1;
      if (int'(bytes_sent) == n) ok = 1'b1;
    end
  endtask

  function automatic int frame_diff(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    if (rx_q.size() > exp_q.size()) n += rx_q.size() - exp_q.size();
    return n;
  endfunction

  function automatic int strobe_bad(input logic [4:0] r);
    int n = 0;
    for (int i = 0; i < 128; i++) if (strobe_cnt[int'(r) * 128 + i] != 1) n++;
    return n;
  endfunction

  // Gaps at frame starts (every FRAME_BYTES-th byte) are idle time, not inter-byte gaps.
  function automatic int gap_bad();
    int n = 0;
    for (int i = 0; i < gap_q.size(); i++) if (i % FRAME_BYTES != 0 && gap_q[i] != 3) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b want 1", tx_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (ram_clk_enable !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_clk_enable); else n_pass++;
    n_checks++; if (ram_address !== 12'h000) $display("FAIL reset_addr: got %h want 000", ram_address); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd0) $display("FAIL reset_bytes_sent: got %0d want 0", bytes_sent); else n_pass++;
    n_checks++; if (state_dbg !== 3'(ST_IDLE)) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
  endtask

  task automatic test_row5();
    bit ok; int d, f;
    fill_pattern(); clear_mon(); exp_row = 5'd5; build_exp(5'd5);
    pulse_start(5'd5);
    wait_idle(8000, ok);
    n_checks++; if (!ok) $display("FAIL row5_timeout: busy still %b want 0", busy); else n_pass++;
    d = frame_diff(f);
    n_checks++; if (d != 0) $display("FAIL row5_frame: %0d bad bytes, first at %0d, got %0d bytes want %0d", d, f, rx_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL row5_done: got %0d pulses want 1", done_cnt); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd132) $display("FAIL row5_bytes_sent: got %0d want 132", bytes_sent); else n_pass++;
    n_checks++; if (strobe_bad(5'd5) != 0) $display("FAIL row5_strobes: got %0d addrs not strobed once want 0", strobe_bad(5'd5)); else n_pass++;
    n_checks++; if (out_of_range != 0) $display("FAIL row5_addr_range: got %0d stray strobes want 0", out_of_range); else n_pass++;
    n_checks++; if (gap_bad() != 0) $display("FAIL row5_gap: got %0d gaps not 3 cycles want 0", gap_bad()); else n_pass++;
    n_checks++; if (cell_err + frame_err != 0) $display("FAIL row5_bit_cells: got %0d cell/%0d stop errors want 0", cell_err, frame_err); else n_pass++;
    n_checks++; if (busy_cyc != BUSY_CYCLES) $display("FAIL row5_frame_len: got %0d cycles want %0d", busy_cyc, BUSY_CYCLES); else n_pass++;
  endtask

  task automatic test_row31();
    bit ok; int d, f;
    fill_random(); clear_mon(); exp_row = 5'd31; build_exp(5'd31);
    pulse_start(5'd31);
    wait_idle(8000, ok);
    n_checks++; if (!ok) $display("FAIL row31_timeout: busy still %b want 0", busy); else n_pass++;
    n_checks++; if (rx_q.size() < 3 || rx_q[1] !== 8'h33 || rx_q[2] !== 8'h31) $display("FAIL row31_header: got %0d bytes, digits %h %h want 33 31", rx_q.size(), (rx_q.size() > 1) ? rx_q[1] : 8'h00, (rx_q.size() > 2) ? rx_q[2] : 8'h00); else n_pass++;
    d = frame_diff(f);
    n_checks++; if (d != 0) $display("FAIL row31_frame: %0d bad bytes, first at %0d", d, f); else n_pass++;
    n_checks++; if (strobe_bad(5'd31) != 0) $display("FAIL row31_strobes: got %0d addrs not strobed once want 0", strobe_bad(5'd31)); else n_pass++;
    n_checks++; if (out_of_range != 0) $display("FAIL row31_addr_range: got %0d stray strobes want 0", out_of_range); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL row31_done: got %0d pulses want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit ok1, ok2; int d, f; logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    fill_random(); clear_mon(); exp_row = r; build_exp(r);
    pulse_start(r);
    wait_bytes(10, 1000, ok1);
    pulse_start(r + 5'd1);
    wait_idle(8000, ok2);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL busy_start_timeout: got %b%b want 11", ok1, ok2); else n_pass++;
    d = frame_diff(f);
    n_checks++; if (d != 0) $display("FAIL busy_start_frame: %0d bad bytes, first at %0d", d, f); else n_pass++;
    n_checks++; if (busy_cyc != BUSY_CYCLES) $display("FAIL busy_start_len: got %0d cycles want %0d", busy_cyc, BUSY_CYCLES); else n_pass++;
    n_checks++; if (out_of_range != 0) $display("FAIL busy_start_addr: got %0d stray strobes want 0", out_of_range); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL busy_start_done: got %0d pulses want 1", done_cnt); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd132) $display("FAIL busy_start_count: got %0d want 132", bytes_sent); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok1, ok2; int d, f, run_at_fall; bit act_at_fall; logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    fill_random(); clear_mon(); exp_row = r; build_exp(r);
    pulse_start(r);
    wait_bytes(50, 3000, ok1);
    repeat ($urandom_range(8, 30)) @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    wait_idle(100, ok2);
    run_at_fall = high_run;
    act_at_fall = rx_active;
    while (exp_q.size() > 51) void'(exp_q.pop_back());
    n_checks++; if (!(ok1 && ok2)) $display("FAIL abort_timeout: got %b%b want 11", ok1, ok2); else n_pass++;
    n_checks++; if (act_at_fall || run_at_fall > 1) $display("FAIL abort_busy_fall: got mid-byte %0d idle %0d want 0 and <=1", act_at_fall, run_at_fall); else n_pass++;
    d = frame_diff(f);
    n_checks++; if (d != 0) $display("FAIL abort_bytes: %0d bad bytes, first at %0d, got %0d bytes want 51", d, f, rx_q.size()); else n_pass++;
    n_checks++; if (cell_err + frame_err != 0) $display("FAIL abort_stop_bit: got %0d cell/%0d stop errors want 0", cell_err, frame_err); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd51) $display("FAIL abort_count: got %0d want 51", bytes_sent); else n_pass++;
    repeat (60) @(negedge clk_in);
    #1;
    n_checks++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); else n_pass++;
    n_checks++; if (rx_q.size() != 51 || rx_active || tx_out !== 1'b1) $display("FAIL abort_line_idle: got %0d bytes tx %b want 51 bytes tx 1", rx_q.size(), tx_out); else n_pass++;
  endtask

  task automatic test_abort_beats_start();
    clear_mon();
    @(negedge clk_in);
    row = 5'($urandom_range(0, 31));
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    abort = 1'b0;
    repeat (50) @(negedge clk_in);
    #1;
    n_checks++; if (busy_cyc != 0) $display("FAIL abort_start_busy: got %0d busy cycles want 0", busy_cyc); else n_pass++;
    n_checks++; if (rx_q.size() != 0 || rx_active) $display("FAIL abort_start_tx: got %0d bytes want 0", rx_q.size()); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd51) $display("FAIL abort_start_count: got %0d want 51 (start not accepted)", bytes_sent); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok1, ok2; int d, f; logic [4:0] r;
    r = 5'($urandom_range(0, 31));
    fill_random(); clear_mon(); exp_row = r;
    pulse_start(r);
    wait_bytes(20, 2000, ok1);
    repeat ($urandom_range(1, 40)) @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (!ok1) $display("FAIL rst_mid_timeout: bytes_sent %0d want 20", bytes_sent); else n_pass++;
    n_checks++; if (tx_out !== 1'b1) $display("FAIL rst_mid_tx_out: got %b want 1", tx_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ram_clk_enable !== 1'b0) $display("FAIL rst_mid_ram_en: got %b want 0", ram_clk_enable); else n_pass++;
    n_checks++; if (bytes_sent !== 8'd0 || ram_address !== 12'h000) $display("FAIL rst_mid_regs: got count %0d addr %h want 0 000", bytes_sent, ram_address); else n_pass++;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    fill_pattern(); clear_mon(); exp_row = 5'd0; build_exp(5'd0);
    pulse_start(5'd0);
    wait_idle(8000, ok2);
    d = frame_diff(f);
    n_checks++; if (!ok2) $display("FAIL rst_after_timeout: busy still %b want 0", busy); else n_pass++;
    n_checks++; if (d != 0) $display("FAIL rst_after_frame: %0d bad bytes, first at %0d", d, f); else n_pass++;
    n_checks++; if (done_cnt != 1 || bytes_sent !== 8'd132) $display("FAIL rst_after_end: got %0d done %0d bytes want 1 132", done_cnt, bytes_sent); else n_pass++;
    n_checks++; if (gap_bad() + cell_err + frame_err != 0) $display("FAIL rst_after_timing: got %0d timing errors want 0", gap_bad() + cell_err + frame_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int d, f; logic [4:0] r1, r2;
    r1 = 5'($urandom_range(0, 31));
    r2 = r1 + 5'($urandom_range(1, 31));
    fill_random(); clear_mon(); exp_row = r1;
    build_exp(r1);
    build_exp(r2);
    pulse_start(r1);
    wait_idle(8000, ok1);
    exp_row = r2;
    pulse_start(r2);
    wait_idle(8000, ok2);
    d = frame_diff(f);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL b2b_timeout: got %b%b want 11", ok1, ok2); else n_pass++;
    n_checks++; if (d != 0) $display("FAIL b2b_frames: %0d bad bytes, first at %0d, got %0d bytes want 264", d, f, rx_q.size()); else n_pass++;
    n_checks++; if (done_cnt != 2) $display("FAIL b2b_done: got %0d pulses want 2", done_cnt); else n_pass++;
    n_checks++; if (busy_cyc != 2 * BUSY_CYCLES) $display("FAIL b2b_len: got %0d cycles want %0d", busy_cyc, 2 * BUSY_CYCLES); else n_pass++;
    n_checks++; if (strobe_bad(r1) + strobe_bad(r2) + out_of_range != 0) $display("FAIL b2b_strobes: got %0d bad want 0", strobe_bad(r1) + strobe_bad(r2) + out_of_range); else n_pass++;
    n_checks++; if (gap_bad() + cell_err + frame_err != 0) $display("FAIL b2b_timing: got %0d timing errors want 0", gap_bad() + cell_err + frame_err); else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_mon();
    repeat (3) @(negedge clk_in);
    #1;
    test_reset();
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    test_row5();
    test_row31();
    test_start_while_busy();
    test_abort();
    test_abort_beats_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/framebuffer_readback_tx.md
Name: framebuffer_readback_tx

Overview:
- Transmit side of the row-load protocol: reads one 64-pixel row (128 bytes) from the 8-bit framebuffer port and serialises it over UART.
- Frame format is the same as the ingest format: "L", two ASCII decimal row digits, 128 raw data bytes, then 0x0A.
- Sits beside control_module on clk_root and shares the multimem A-side read path (QA/AddressA/ClockEnA).
- Used for host-side framebuffer verification; triggered by a debugger command.

Parameters:
- TICKS_PER_BIT, 20, clk_in ticks per UART bit (2.5 Mbaud at 50 MHz).
- TICKS_WIDTH, 5, width of the bit-tick counter.
- BYTES_PER_ROW, 128, data bytes per row; must be a power of 2.
- ADDR_WIDTH, 12, framebuffer byte-address width (5 row bits + 7 byte bits).

Ports:
- clk_in  in  1  system clock (clk_root)
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request strobe; ignored while busy
- row  in  5  row to dump (0..31); sampled on the accepted start
- abort  in  1  synchronous cancel
- ram_data_in  in  8  framebuffer read data, valid 1 cycle after ram_clk_enable
- ram_address  out  12  framebuffer byte address = {row, byte_index[6:0]}
- ram_clk_enable  out  1  read strobe, one cycle per byte
- tx_out  out  1  UART serial out, 8N1, LSB first, idle high
- busy  out  1  high from accepted start until frame end or abort
- done  out  1  one-cycle pulse after the stop bit of 0x0A
- bytes_sent  out  8  count of completed bytes in the current frame (debugger visibility)

Behaviour:
- Reset (async assert, sync release) drives outputs to: tx_out=1, busy=0, done=0, ram_clk_enable=0, ram_address=0, bytes_sent=0; FSM goes to IDLE.
- FSM states and transitions:
  - IDLE: start accepted -> latch row, busy=1 on the next cycle, go to HDR.
  - HDR: send 0x4C ("L"), then 0x30+row/10, then 0x30+row%10. Row 7 sends "07"; row 31 sends "31".
  - FETCH: assert ram_clk_enable for 1 cycle with ram_address={row_q, idx}.
  - WAIT: capture ram_data_in into the tx holding register next cycle.
  - SEND: hand the byte to uart_tx; on byte-done, idx+1; idx==BYTES_PER_ROW-1 -> TRAIL, else FETCH.
  - TRAIL: send 0x0A.
  - FIN: pulse done, clear busy, return to IDLE.
- FETCH->WAIT->load fits inside the previous stop bit's trailing cycles? No: bytes are strictly sequential, so the inter-byte gap is exactly 3 clk_in cycles (FETCH, WAIT, load) of idle-high line.
- Frame length: 132 bytes x 10 bits x TICKS_PER_BIT + 131 x 3 gap cycles + 3 header-load cycles.
- UART bit cell: exactly TICKS_PER_BIT cycles. Start bit 0, data LSB first, stop bit 1.
- bytes_sent increments at each stop-bit end, covers header+data+trailer (final value 132, mod 256), and clears on an accepted start.
- start while busy: ignored, no queuing. start and abort in the same cycle while IDLE: abort wins, nothing sent.
- abort while busy:
  - Any in-progress UART byte completes, including its stop bit, so the line never glitches.
  - Then -> IDLE, busy=0, no done pulse.
- idx wraps only through the TRAIL transition; no address ever leaves the row_q region.
- ram_clk_enable is never asserted outside FETCH. The caller arbitrates with control_module writes; this block assumes read ownership while busy.

Decomposition:
- Shared package: the protocol constants (CMD_ROW_LOAD=0x4C, FRAME_TERM=0x0A, ASCII_ZERO=0x30, BYTES_PER_ROW) and the FSM state encoding, shared with control_module's receive parser.
- One sub-module: uart_tx_byte (load/byte_done handshake, bit and tick counters, tx_out). Parameters TICKS_PER_BIT and TICKS_WIDTH are passed through.

Test Plan:
- TICKS_PER_BIT=4; RAM model returns addr[7:0]; start with row=5 -> decoded bytes 4C 30 35 80..FF 0A. Addresses 0x280..0x2FF each strobed once. done pulses once; bytes_sent=132.
- row=31 -> header 4C 33 31; addresses 0xF80..0xFFF; no address outside that range.
- start pulsed again at bytes_sent=10 -> ignored; the frame is identical to the single-start case.
- abort mid-byte 50 -> current byte finishes with stop bit high; busy falls within 1 cycle after; no done; tx_out stays 1 afterward.
- reset asserted mid-frame -> tx_out=1, busy=0, ram_clk_enable=0 immediately (async). After release, start row=0 yields a clean frame 4C 30 30 ...
- Bit timing check: each bit cell measures exactly 4 cycles; the inter-byte idle gap measures exactly 3 cycles.
